// File: rtl/cmd_responder.sv
// cmd_responder: collects a CR-terminated command line from a UART byte
// stream into a line buffer, then answers with "AOK\r\n" or "ERR\r\n".
// The line buffer can be read back through a registered read port.
//
// state | meaning
// ------+--------------------------------------------------------------
// RCV   | collecting bytes; CR ends the line
// LOAD  | reply byte 0 loaded into tx_data, line counters cleared
// SEND  | issue trmt for the byte held in tx_data
// WAIT  | wait for tx_done, then load next byte or return to RCV
module cmd_responder #(
    parameter  int CMD_MAX = 16,
    localparam int W       = $clog2(CMD_MAX + 1),
    localparam int AW      = $clog2(CMD_MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_rdy,
    input  logic [7:0]   rx_data,
    output logic         clr_rx_rdy,
    output logic         trmt,
    output logic [7:0]   tx_data,
    input  logic         tx_done,
    output logic         cmd_done,
    output logic         cmd_ok,
    output logic [W-1:0] cmd_len,
    input  logic [W-1:0] cmd_rd_addr,
    output logic [7:0]   cmd_rd_data,
    output logic         resp_busy
);

    typedef enum logic [1:0] {S_RCV, S_LOAD, S_SEND, S_WAIT} state_t;

    state_t         state_q;
    logic [W-1:0]   count_q;
    logic           ovf_q;
    logic [2:0]     idx_q;
    logic           trmt_q;
    logic           cmd_done_q;
    logic           cmd_ok_q;
    logic [W-1:0]   cmd_len_q;
    logic [7:0]     tx_data_q;
    logic [7:0]     rd_data_q;
    logic [7:0]     buf_q [CMD_MAX];

    logic           is_cr;
    logic           is_lf;
    logic           buf_we_d;

    function automatic logic [7:0] reply_byte(input logic ok, input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = ok ? 8'h41 : 8'h45;
            3'd1:    b = ok ? 8'h4F : 8'h52;
            3'd2:    b = ok ? 8'h4B : 8'h52;
            3'd3:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    // Every offered byte is consumed, whatever the state.
    assign clr_rx_rdy = rx_rdy;

    assign is_cr    = (rx_data == 8'h0D);
    assign is_lf    = (rx_data == 8'h0A);
    assign buf_we_d = !rst && (state_q == S_RCV) && rx_rdy && !is_cr && !is_lf
                      && (count_q < W'(CMD_MAX));

    // Line collection, reply sequencing and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RCV;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            idx_q      <= '0;
            trmt_q     <= 1'b0;
            cmd_done_q <= 1'b0;
            cmd_ok_q   <= 1'b0;
            cmd_len_q  <= '0;
            tx_data_q  <= '0;
        end else begin
            trmt_q     <= 1'b0;
            cmd_done_q <= 1'b0;
            case (state_q)
                S_RCV: begin
                    if (rx_rdy && !is_lf) begin
                        if (is_cr) begin
                            // count never exceeds CMD_MAX, so it is already saturated
                            cmd_len_q  <= count_q;
                            cmd_ok_q   <= (count_q != '0) && !ovf_q;
                            cmd_done_q <= 1'b1;
                            state_q    <= S_LOAD;
                        end else if (count_q < W'(CMD_MAX)) begin
                            count_q <= count_q + W'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    idx_q     <= '0;
                    tx_data_q <= reply_byte(cmd_ok_q, 3'd0);
                    count_q   <= '0;
                    ovf_q     <= 1'b0;
                    state_q   <= S_SEND;
                end
                S_SEND: begin
                    trmt_q  <= 1'b1;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // tx_done may still show the previous byte while trmt is high
                    if (tx_done && !trmt_q) begin
                        if (idx_q < 3'd4) begin
                            idx_q     <= idx_q + 3'd1;
                            tx_data_q <= reply_byte(cmd_ok_q, idx_q + 3'd1);
                            state_q   <= S_SEND;
                        end else begin
                            state_q <= S_RCV;
                        end
                    end
                end
                default: state_q <= S_RCV;
            endcase
        end
    end

    // Line buffer storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (buf_we_d) begin
            buf_q[count_q[AW-1:0]] <= rx_data;
        end
    end

    // Registered buffer read port; out-of-range addresses read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (cmd_rd_addr < W'(CMD_MAX)) begin
            rd_data_q <= buf_q[cmd_rd_addr[AW-1:0]];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign trmt        = trmt_q;
    assign tx_data     = tx_data_q;
    assign cmd_done    = cmd_done_q;
    assign cmd_ok      = cmd_ok_q;
    assign cmd_len     = cmd_len_q;
    assign cmd_rd_data = rd_data_q;
    assign resp_busy   = (state_q != S_RCV);

endmodule

// File: tb/tb_cmd_responder.sv
// Directed bench for cmd_responder with a simple UART transmit model.
module tb_cmd_responder;

    localparam int CMD_MAX = 16;
    localparam int W       = $clog2(CMD_MAX + 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_rdy = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         clr_rx_rdy;
    logic         trmt;
    logic [7:0]   tx_data;
    logic         tx_done = 1'b0;
    logic         cmd_done;
    logic         cmd_ok;
    logic [W-1:0] cmd_len;
    logic [W-1:0] cmd_rd_addr = '0;
    logic [7:0]   cmd_rd_data;
    logic         resp_busy;

    cmd_responder #(.CMD_MAX(CMD_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .cmd_done    (cmd_done),
        .cmd_ok      (cmd_ok),
        .cmd_len     (cmd_len),
        .cmd_rd_addr (cmd_rd_addr),
        .cmd_rd_data (cmd_rd_data),
        .resp_busy   (resp_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int trmt_cnt = 0;
    int first_trmt_cyc = 0;
    logic [7:0] tx_q[$];

    logic [7:0] aok[5] = '{8'h41, 8'h4F, 8'h4B, 8'h0D, 8'h0A};
    logic [7:0] err[5] = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (cmd_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // UART transmitter: captures tx_data on trmt, raises tx_done 20 clocks later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (trmt) begin
                if (trmt_cnt == 0) first_trmt_cyc = cyc;
                trmt_cnt++;
                tx_q.push_back(tx_data);
                tx_done = 1'b0;
                repeat (19) @(posedge clk);
                #1 tx_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_rdy  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input int addr, input logic [7:0] exp);
        @(negedge clk);
        cmd_rd_addr = W'(addr);
        @(negedge clk);
        chk(tag, 32'(cmd_rd_data), 32'(exp));
    endtask

    task automatic wait_reply(input string tag);
        int t;
        t = 0;
        while (!(trmt_cnt == 5 && !resp_busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_timeout"}, 32'(t < 500), 32'd1);
        repeat (30) @(negedge clk);
    endtask

    task automatic run_line(input string tag, input string s, input logic ok,
                            input int len, input bit inject);
        int d0;
        d0 = done_cnt;
        trmt_cnt = 0;
        first_trmt_cyc = 0;
        tx_q.delete();
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        if (inject) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(resp_busy), 32'd1);
            rx_rdy  = 1'b1;
            rx_data = 8'h58;
            #1;
            chk({tag, "_clr"}, 32'(clr_rx_rdy), 32'd1);
            @(negedge clk);
            rx_rdy = 1'b0;
        end
        wait_reply(tag);
        chk({tag, "_ndone"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_len"}, 32'(cmd_len), 32'(len));
        chk({tag, "_ok"}, 32'(cmd_ok), 32'(ok));
        chk({tag, "_ntrmt"}, 32'(trmt_cnt), 32'd5);
        chk({tag, "_lat"}, 32'(first_trmt_cyc - done_cyc), 32'd2);
        chk({tag, "_nbytes"}, 32'(tx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < tx_q.size(); i++)
            chk({tag, "_tx", $sformatf("%0d", i)}, 32'(tx_q[i]), 32'(ok ? aok[i] : err[i]));
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_trmt", 32'(trmt), 32'd0);
        chk("rst_done", 32'(cmd_done), 32'd0);
        chk("rst_ok", 32'(cmd_ok), 32'd0);
        chk("rst_len", 32'(cmd_len), 32'd0);
        chk("rst_txd", 32'(tx_data), 32'd0);
        chk("rst_rdd", 32'(cmd_rd_data), 32'd0);
        chk("rst_busy", 32'(resp_busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic command line
        run_line("t1", "S%,07\r", 1'b1, 5, 1'b0);
        rd_chk("t2_rd0", 0, 8'h53);
        rd_chk("t2_rd1", 1, 8'h25);
        rd_chk("t2_rd2", 2, 8'h2C);
        rd_chk("t2_rd3", 3, 8'h30);
        rd_chk("t2_rd4", 4, 8'h37);

        // empty line
        run_line("t3", "\r", 1'b0, 0, 1'b0);

        // overflow then recovery
        run_line("t4a", "AAAAAAAAAAAAAAAAAAAA\r", 1'b0, 16, 1'b0);
        rd_chk("t4_rd15", 15, 8'h41);
        run_line("t4b", "B\r", 1'b1, 1, 1'b0);

        // LF ignored; byte during reply discarded
        run_line("t5a", "A\nB\r", 1'b1, 2, 1'b0);
        rd_chk("t5_rd0", 0, 8'h41);
        rd_chk("t5_rd1", 1, 8'h42);
        run_line("t5b", "E\r", 1'b1, 1, 1'b1);
        run_line("t5c", "DF\r", 1'b1, 2, 1'b0);
        rd_chk("t5_rdD", 0, 8'h44);
        rd_chk("t5_rdF", 1, 8'h46);

        // reset in the middle of a reply
        trmt_cnt = 0;
        send_byte(8'h51);
        send_byte(8'h0D);
        t = 0;
        while (trmt_cnt < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("t6_timeout", 32'(t < 200), 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("t6_ntrmt", 32'(trmt_cnt), 32'd2);
        chk("t6_busy", 32'(resp_busy), 32'd0);
        chk("t6_len", 32'(cmd_len), 32'd0);
        chk("t6_ok", 32'(cmd_ok), 32'd0);
        run_line("t6c", "C\r", 1'b1, 1, 1'b0);
        rd_chk("t6_rd0", 0, 8'h43);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
